// File: rtl/fir_mac_engine.sv
// fir_mac_engine: serial multiply-accumulate FIR between the I2S ADC and DAC data ports.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   adcData/adcDataValid  signed input sample with one-cycle valid pulse
//   dacData/dacDataValid  signed filtered sample with one-cycle update pulse
//   coeffWrite/coeffAddr/coeffData  coefficient bank write port (accepted only when idle)
//   coeffReady, busy      idle / computing status
//   overrun               one-cycle pulse when a sample arrives while busy and is dropped
module fir_mac_engine #(
    parameter int DataWidth  = 12,
    parameter int Taps       = 8,
    parameter int CoeffWidth = 8,
    parameter int CoeffShift = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [DataWidth-1:0]   adcData,
    input  logic                          adcDataValid,
    output logic signed [DataWidth-1:0]   dacData,
    output logic                          dacDataValid,
    input  logic                          coeffWrite,
    input  logic [$clog2(Taps)-1:0]       coeffAddr,
    input  logic signed [CoeffWidth-1:0]  coeffData,
    output logic                          coeffReady,
    output logic                          busy,
    output logic                          overrun
);
    localparam int PtrWidth  = $clog2(Taps);
    localparam int ProdWidth = DataWidth + CoeffWidth;
    localparam int AccWidth  = DataWidth + CoeffWidth + PtrWidth;
    localparam logic signed [AccWidth-1:0] MaxVal = AccWidth'((1 << (DataWidth - 1)) - 1);
    localparam logic signed [AccWidth-1:0] MinVal = ~MaxVal;

    typedef enum logic [1:0] {IDLE, MAC, OUT} stateType;

    stateType                     state, nextState;
    logic signed [DataWidth-1:0]  hist  [Taps];
    logic signed [CoeffWidth-1:0] coeff [Taps];
    logic [PtrWidth-1:0]          wrPtr, k, histIdx;
    logic signed [AccWidth-1:0]   acc, prodExt, shifted;
    logic signed [ProdWidth-1:0]  product;
    logic signed [DataWidth-1:0]  satData;
    logic                         lastTap;

    assign busy       = (state != IDLE);
    assign coeffReady = !busy;
    assign lastTap    = (k == PtrWidth'(Taps - 1));

    // Newest sample sits at wrPtr, so tap k reaches back k samples; the
    // pointer width makes the subtraction wrap modulo Taps.
    assign histIdx = wrPtr - k;
    assign product = ProdWidth'(coeff[k]) * ProdWidth'(hist[histIdx]);
    assign prodExt = AccWidth'(product);
    assign shifted = acc >>> CoeffShift;
    assign satData = (shifted > MaxVal) ? MaxVal[DataWidth-1:0] :
                     (shifted < MinVal) ? MinVal[DataWidth-1:0] : shifted[DataWidth-1:0];

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (state == IDLE && adcDataValid)
            nextState = MAC;
        else if (state == MAC && lastTap)
            nextState = OUT;
        else if (state == OUT)
            nextState = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Taps; i++) begin
                hist[i]  <= '0;
                coeff[i] <= (i == 0) ? CoeffWidth'(1 << CoeffShift) : '0;
            end
            wrPtr        <= '0;
            k            <= '0;
            acc          <= '0;
            dacData      <= '0;
            dacDataValid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            dacDataValid <= 1'b0;
            overrun      <= adcDataValid && busy;
            case (state)
                IDLE: begin
                    if (adcDataValid) begin
                        hist[wrPtr] <= adcData;
                        acc         <= '0;
                        k           <= '0;
                    end
                    if (coeffWrite)
                        coeff[coeffAddr] <= coeffData;
                end
                MAC: begin
                    acc <= acc + prodExt;
                    k   <= k + 1'b1;
                    if (lastTap)
                        wrPtr <= wrPtr + 1'b1;
                end
                OUT: begin
                    dacData      <= satData;
                    dacDataValid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: directed self-checking bench for fir_mac_engine (Taps=8, CoeffShift=6).
module tb_fir_mac_engine;
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [11:0] adcData = '0;
    logic               adcDataValid = 1'b0;
    logic signed [11:0] dacData;
    logic               dacDataValid;
    logic               coeffWrite = 1'b0;
    logic [2:0]         coeffAddr = '0;
    logic signed [7:0]  coeffData = '0;
    logic               coeffReady;
    logic               busy;
    logic               overrun;
    int                 errors = 0;
    int                 checks = 0;

    fir_mac_engine dut (
        .clk(clk), .reset(reset),
        .adcData(adcData), .adcDataValid(adcDataValid),
        .dacData(dacData), .dacDataValid(dacDataValid),
        .coeffWrite(coeffWrite), .coeffAddr(coeffAddr), .coeffData(coeffData),
        .coeffReady(coeffReady), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic writeCoeff(input int a, input int d);
        coeffAddr  = 3'(a);
        coeffData  = 8'(d);
        coeffWrite = 1'b1;
        tick();
        coeffWrite = 1'b0;
    endtask

    task automatic startSample(input int v);
        adcData      = 12'(v);
        adcDataValid = 1'b1;
        tick();
        adcDataValid = 1'b0;
    endtask

    task automatic waitOut(input string tag, input int exp, input bit chk, output int cyc);
        cyc = 0;
        while (!dacDataValid && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, " valid"}, int'(dacDataValid), 1);
        if (chk)
            check(tag, int'(dacData), exp);
        tick();
        check({tag, " pulse"}, int'(dacDataValid), 0);
    endtask

    task automatic countPulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (dacDataValid)
                pulses++;
        end
    endtask

    initial begin
        int cyc;
        int pulses;
        int impCoef [8] = '{10, 20, 30, 40, 50, 60, 70, -80};

        repeat (3) tick();
        check("rst dacData", int'(dacData), 0);
        check("rst dacDataValid", int'(dacDataValid), 0);
        check("rst overrun", int'(overrun), 0);
        check("rst busy", int'(busy), 0);
        check("rst coeffReady", int'(coeffReady), 1);
        reset = 1'b0;
        tick();

        startSample(100);
        check("busy in MAC", int'(busy), 1);
        waitOut("id 100", 100, 1'b1, cyc);
        check("latency", cyc + 1, 10);
        startSample(-2048);
        waitOut("id -2048", -2048, 1'b1, cyc);
        startSample(2047);
        waitOut("id 2047", 2047, 1'b1, cyc);

        doReset();
        for (int i = 0; i < 8; i++)
            writeCoeff(i, impCoef[i]);
        for (int i = 0; i < 8; i++) begin
            startSample(i == 0 ? 64 : 0);
            waitOut($sformatf("impulse %0d", i), impCoef[i], 1'b1, cyc);
            tick();
        end

        doReset();
        for (int i = 0; i < 8; i++)
            writeCoeff(i, 127);
        for (int i = 0; i < 8; i++) begin
            startSample(2047);
            waitOut("sat hi", 2047, i == 7, cyc);
        end
        for (int i = 0; i < 8; i++) begin
            startSample(-2048);
            waitOut("sat lo", -2048, i == 7, cyc);
        end

        doReset();
        writeCoeff(0, 1);
        startSample(63);
        waitOut("round 63", 0, 1'b1, cyc);
        startSample(-1);
        waitOut("round -1", -1, 1'b1, cyc);
        startSample(64);
        waitOut("round 64", 1, 1'b1, cyc);

        doReset();
        writeCoeff(1, 64);
        startSample(200);
        tick();
        tick();
        adcData      = 12'(999);
        adcDataValid = 1'b1;
        tick();
        adcDataValid = 1'b0;
        check("overrun pulse", int'(overrun), 1);
        tick();
        check("overrun clear", int'(overrun), 0);
        waitOut("ovr out", 200, 1'b1, cyc);
        countPulses(12, pulses);
        check("ovr extra pulses", pulses, 0);
        startSample(10);
        waitOut("after drop", 210, 1'b1, cyc);

        startSample(64);
        tick();
        tick();
        check("coeffReady busy", int'(coeffReady), 0);
        writeCoeff(1, 0);
        waitOut("guard cur", 74, 1'b1, cyc);
        startSample(5);
        waitOut("guard next", 69, 1'b1, cyc);

        startSample(300);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst busy", int'(busy), 0);
        check("midrst valid", int'(dacDataValid), 0);
        check("midrst coeffReady", int'(coeffReady), 1);
        check("midrst dacData", int'(dacData), 0);
        countPulses(12, pulses);
        check("midrst pulses", pulses, 0);
        startSample(100);
        waitOut("midrst id", 100, 1'b1, cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
